fb_port_arbiter: RTL and testbench

- Shares one single-port synchronous frame-buffer RAM between two requesters: VGA scanout reads (hard priority, never stalled) and filter-output writes (buffered, drained in idle cycles).
- Double-buffers the frame: scanout reads the front bank and the writer fills the back bank.
- Banks swap at the start of the vsync pulse once the writer has committed a complete frame.
- Sits between the 640x480 sync generator / pixel pipeline and the Wiener-filter output stage, all in the pclk domain.

---
 rtl/fb_port_arbiter_if.sv | 36 +++
 rtl/fb_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_fb_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_port_arbiter_if
// Brief    : Scanout, writer and frame-buffer RAM port bundle for fb_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              sc_req;
  logic [ADDR_W-1:0] sc_addr;
  logic              sc_rvalid;
  logic [DATA_W-1:0] sc_rdata;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_frame_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  sc_req, sc_addr, wr_valid, wr_addr, wr_data, wr_frame_done, mem_rdata,
    output sc_rvalid, sc_rdata, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output sc_req, sc_addr, wr_valid, wr_addr, wr_data, wr_frame_done, mem_rdata,
    input  sc_rvalid, sc_rdata, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_port_arbiter
// Brief    : Double-buffered frame-buffer port arbiter; scanout reads win, writes
//            drain from a FIFO. Optional stall counter via macro FB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fb_port_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  wire logic        pclk,
  input  wire logic        rst,
  input  wire logic        vsync,
  fb_port_arbiter_if.slave bus,
  output logic             front_bank,
  output logic             swap_pulse,
  output logic [15:0]      stall_cycles
);

  localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(FIFO_DEPTH);
  localparam logic [0:0]         c_ST_RUN  = 1'b0;
  localparam logic [0:0]         c_ST_PEND = 1'b1;

  logic [ADDR_W-1:0]  r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]  r_fifo_data [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wptr, r_rptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_full, w_empty, w_push, w_pop, w_wr_ready;

  logic               r_mem_en, r_mem_we, r_sc_rvalid;
  logic [ADDR_W:0]    r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;

  logic [0:0]         r_state, w_state_nxt;
  logic               r_vsync_q, w_vs_start, w_in_run, w_swap_go;
  logic               r_front_bank, r_swap_pulse;

  // ---------------- write FIFO ----------------
  assign w_full     = (r_count == c_FULL);
  assign w_empty    = (r_count == '0);
  assign w_wr_ready = !rst && !w_full && w_in_run;
  assign w_push     = bus.wr_valid && w_wr_ready;
  assign w_pop      = !bus.sc_req && !w_empty;

  always_ff @(posedge pclk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= bus.wr_addr;
      r_fifo_data[r_wptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- RAM port (one grant per cycle, scanout first) ----------------
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_sc_rvalid <= 1'b0;
    end else begin
      r_mem_en    <= bus.sc_req || w_pop;
      r_mem_we    <= w_pop;
      r_sc_rvalid <= r_mem_en && !r_mem_we;
      if (bus.sc_req) begin
        r_mem_addr <= {r_front_bank, bus.sc_addr};
      end else if (w_pop) begin
        r_mem_addr  <= {~r_front_bank, r_fifo_addr[r_rptr]};
        r_mem_wdata <= r_fifo_data[r_rptr];
      end
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.sc_rvalid = r_sc_rvalid;
  assign bus.sc_rdata  = bus.mem_rdata;
  assign bus.wr_ready  = w_wr_ready;

  // ---------------- swap FSM ----------------
  assign w_vs_start = r_vsync_q && !vsync;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state   <= c_ST_RUN;
      r_vsync_q <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_vsync_q <= vsync;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN:  if (bus.wr_frame_done) w_state_nxt = c_ST_PEND;
      c_ST_PEND: if (w_swap_go)         w_state_nxt = c_ST_RUN;
      default:                          w_state_nxt = c_ST_RUN;
    endcase
  end

  always_comb begin
    w_in_run  = (r_state == c_ST_RUN);
    w_swap_go = (r_state == c_ST_PEND) && w_vs_start && w_empty && !w_pop;
  end

  // Reads already latched keep their bank bit; the toggle lands the cycle after.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_front_bank <= 1'b0;
      r_swap_pulse <= 1'b0;
    end else begin
      r_swap_pulse <= w_swap_go;
      if (w_swap_go) r_front_bank <= ~r_front_bank;
    end
  end

  assign front_bank = r_front_bank;
  assign swap_pulse = r_swap_pulse;

`ifdef FB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge pclk) begin
    if (rst || r_swap_pulse) begin
      r_stall_cnt <= 16'd0;
    end else if (bus.wr_valid && !w_wr_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_port_arbiter
// Brief    : Directed self-checking bench for fb_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_port_arbiter;

  localparam int c_ADDR_W = 19;
  localparam int c_DATA_W = 8;
  localparam logic [31:0] c_BANK1 = 32'h0008_0000;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vsync;
  logic        front_bank;
  logic        swap_pulse;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  fb_port_arbiter_if #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) bus ();

  fb_port_arbiter #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W), .FIFO_DEPTH(16)) dut (
    .pclk         (pclk),
    .rst          (rst),
    .vsync        (vsync),
    .bus          (bus),
    .front_bank   (front_bank),
    .swap_pulse   (swap_pulse),
    .stall_cycles (stall_cycles)
  );

  always #20 pclk = ~pclk;

  // RAM read model: data = low address byte + 0x30, one cycle after the read.
  always @(posedge pclk) begin
    if (rst)
      bus.mem_rdata <= 8'h00;
    else if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= bus.mem_addr[7:0] + 8'h30;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    vsync = 1'b1;
    bus.sc_req = 1'b0;
    bus.sc_addr = '0;
    bus.wr_valid = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_frame_done = 1'b0;
    repeat (3) tick();

    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_sc_rvalid", bus.sc_rvalid, 0);
    check("rst_front_bank", front_bank, 0);
    check("rst_swap_pulse", swap_pulse, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_stall", stall_cycles, 0);
    rst = 1'b0;
    #1;
    check("wr_ready_after_rst", bus.wr_ready, 1);
    tick();

    // Scanout read at address 5
    bus.sc_req = 1'b1;
    bus.sc_addr = 19'd5;
    tick();
    bus.sc_req = 1'b0;
    check("rd_mem_en", bus.mem_en, 1);
    check("rd_mem_we", bus.mem_we, 0);
    check("rd_mem_addr", bus.mem_addr, 32'h5);
    tick();
    check("rd_rvalid", bus.sc_rvalid, 1);
    check("rd_rdata", bus.sc_rdata, 32'h35);
    check("rd_idle_en", bus.mem_en, 0);
    tick();
    check("rd_rvalid_drop", bus.sc_rvalid, 0);

    // Single push drained in idle cycle
    bus.wr_valid = 1'b1;
    bus.wr_addr = 19'd100;
    bus.wr_data = 8'hAB;
    tick();
    bus.wr_valid = 1'b0;
    check("wr1_idle_en", bus.mem_en, 0);
    tick();
    check("wr1_en", bus.mem_en, 1);
    check("wr1_we", bus.mem_we, 1);
    check("wr1_addr", bus.mem_addr, c_BANK1 | 32'd100);
    check("wr1_data", bus.mem_wdata, 32'hAB);
    tick();
    check("wr1_after_en", bus.mem_en, 0);

    // Fill FIFO while scanout holds the port
    bus.sc_req = 1'b1;
    bus.sc_addr = 19'd9;
    for (int i = 0; i < 17; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr = 19'(200 + i);
      bus.wr_data = 8'(8'h10 + i);
      check($sformatf("fill_ready_%0d", i), bus.wr_ready, (i < 16) ? 1 : 0);
      tick();
      check($sformatf("fill_we_%0d", i), bus.mem_we, 0);
    end
    bus.wr_valid = 1'b0;
`ifdef FB_STATS_EN
    check("fill_stall", stall_cycles, 1);
`else
    check("fill_stall", stall_cycles, 0);
`endif
    bus.sc_req = 1'b0;
    for (int j = 0; j < 16; j++) begin
      tick();
      check($sformatf("drain_we_%0d", j), bus.mem_we, 1);
      check($sformatf("drain_addr_%0d", j), bus.mem_addr, c_BANK1 | 32'(200 + j));
      check($sformatf("drain_data_%0d", j), bus.mem_wdata, 32'(8'h10 + j));
      if (j == 0) check("drain_ready", bus.wr_ready, 1);
    end
    tick();
    check("drain_idle", bus.mem_en, 0);

    // Frame done with 3 queued, then vsync swap
    bus.sc_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr = 19'(300 + i);
      bus.wr_data = 8'(8'h60 + i);
      bus.wr_frame_done = (i == 2);
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.wr_frame_done = 1'b0;
    check("pend_ready", bus.wr_ready, 0);
    check("pend_front", front_bank, 0);
    bus.sc_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("fd_addr_%0d", j), bus.mem_addr, c_BANK1 | 32'(300 + j));
      check($sformatf("fd_data_%0d", j), bus.mem_wdata, 32'(8'h60 + j));
    end
    repeat (6) tick();
    check("pre_swap_pulse", swap_pulse, 0);
    vsync = 1'b0;
    tick();
    check("swap1_pulse", swap_pulse, 1);
    check("swap1_front", front_bank, 1);
    check("swap1_ready", bus.wr_ready, 1);
    tick();
    check("swap1_pulse_drop", swap_pulse, 0);
    vsync = 1'b1;
    bus.sc_req = 1'b1;
    bus.sc_addr = 19'd7;
    tick();
    bus.sc_req = 1'b0;
    check("rd_bank1_addr", bus.mem_addr, c_BANK1 | 32'd7);
    tick();

    // Swap blocked by continuous scanout with FIFO non-empty
    bus.sc_req = 1'b1;
    bus.sc_addr = 19'd3;
    for (int i = 0; i < 2; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr = 19'(400 + i);
      bus.wr_data = 8'(8'h70 + i);
      bus.wr_frame_done = (i == 1);
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.wr_frame_done = 1'b0;
    repeat (2) tick();
    vsync = 1'b0;
    tick();
    check("blk_pulse", swap_pulse, 0);
    check("blk_front", front_bank, 1);
    tick();
    check("blk_pulse2", swap_pulse, 0);
    vsync = 1'b1;
    bus.sc_req = 1'b0;
    for (int j = 0; j < 2; j++) begin
      tick();
      check($sformatf("blk_addr_%0d", j), bus.mem_addr, 32'(400 + j));
      check($sformatf("blk_data_%0d", j), bus.mem_wdata, 32'(8'h70 + j));
    end
    repeat (3) tick();
    vsync = 1'b0;
    tick();
    check("swap2_pulse", swap_pulse, 1);
    check("swap2_front", front_bank, 0);
    vsync = 1'b1;
    tick();

    // Writer stalled 40 cycles while pending
    bus.wr_frame_done = 1'b1;
    tick();
    bus.wr_frame_done = 1'b0;
    check("stall_pend_ready", bus.wr_ready, 0);
    bus.wr_valid = 1'b1;
    bus.wr_addr = 19'd500;
    repeat (40) tick();
    bus.wr_valid = 1'b0;
`ifdef FB_STATS_EN
    check("stall_40", stall_cycles, 40);
`else
    check("stall_40", stall_cycles, 0);
`endif
    vsync = 1'b0;
    tick();
    check("swap3_pulse", swap_pulse, 1);
    check("swap3_front", front_bank, 1);
    tick();
    check("stall_cleared", stall_cycles, 0);
    vsync = 1'b1;
    tick();

    // Reset mid-operation flushes FIFO and pending swap
    bus.sc_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr = 19'(600 + i);
      bus.wr_data = 8'(8'h80 + i);
      bus.wr_frame_done = (i == 1);
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.wr_frame_done = 1'b0;
    check("mid_pend_ready", bus.wr_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.sc_req = 1'b0;
    #1;
    check("mid_rst_front", front_bank, 0);
    check("mid_rst_ready", bus.wr_ready, 1);
    tick();
    check("mid_rst_flushed", bus.mem_en, 0);
    vsync = 1'b0;
    tick();
    check("mid_rst_no_swap", swap_pulse, 0);
    vsync = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
